// File: rtl/rf_write_arbiter_if.sv
// Writeback bundle between the core/accelerator producers, decode and the register-file write port.
// The slave modport is the arbiter side; the master modport is the producer/consumer side.
interface rf_write_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              core_wb_en;
  logic [4:0]        core_rd;
  logic [DATA_W-1:0] core_data;
  logic              acc_valid;
  logic              acc_ready;
  logic [4:0]        acc_rd;
  logic [DATA_W-1:0] acc_data;
  logic              acc_issue_en;
  logic [4:0]        acc_issue_rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              stall_rs1;
  logic              stall_rs2;
  logic              write_reg;
  logic [4:0]        rd;
  logic [DATA_W-1:0] data_in;

  modport slave (
    input  core_wb_en, core_rd, core_data,
    input  acc_valid, acc_rd, acc_data,
    input  acc_issue_en, acc_issue_rd,
    input  rs1, rs2,
    output acc_ready, stall_rs1, stall_rs2,
    output write_reg, rd, data_in
  );

  modport master (
    output core_wb_en, core_rd, core_data,
    output acc_valid, acc_rd, acc_data,
    output acc_issue_en, acc_issue_rd,
    output rs1, rs2,
    input  acc_ready, stall_rs1, stall_rs2,
    input  write_reg, rd, data_in
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Merges core and accelerator writebacks onto the register file's single write port, with a
// result FIFO and a pending scoreboard. Define RF_WB_FIFO_BYPASS_EN for empty-FIFO bypass.
module rf_write_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 32
) (
  input logic               clk,
  input logic               reset,
  rf_write_arbiter_if.slave wb
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              ready_q;
  logic [31:0]       pending_q, pending_d;
  logic              write_reg_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] data_q;

  logic              empty, accept, push, pop;
  logic              sel_valid, sel_acc;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign empty  = (count_q == '0);
  // ready_q is a registered copy of !full, so acceptance never depends combinationally on valid.
  assign accept = wb.acc_valid && ready_q;

  // Core wins; the FIFO head drains only on core-idle cycles.
  always_comb begin
    push      = accept;
    pop       = 1'b0;
    sel_valid = 1'b0;
    sel_acc   = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (wb.core_wb_en) begin
      sel_valid = 1'b1;
      sel_rd    = wb.core_rd;
      sel_data  = wb.core_data;
    end else if (!empty) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_acc   = 1'b1;
      sel_rd    = fifo_q[rd_ptr_q].rd;
      sel_data  = fifo_q[rd_ptr_q].data;
    end
`ifdef RF_WB_FIFO_BYPASS_EN
    else if (accept) begin
      push      = 1'b0;
      sel_valid = 1'b1;
      sel_acc   = 1'b1;
      sel_rd    = wb.acc_rd;
      sel_data  = wb.acc_data;
    end
`endif
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Clear before set so an issue colliding with a retiring write keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (sel_acc) begin
      pending_d[sel_rd] = 1'b0;
    end
    if (wb.acc_issue_en) begin
      pending_d[wb.acc_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{rd: wb.acc_rd, data: wb.acc_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      pending_q   <= '0;
      write_reg_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q     <= count_d;
      ready_q     <= (count_d != CntW'(FIFO_DEPTH));
      pending_q   <= pending_d;
      write_reg_q <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        rd_q   <= sel_rd;
        data_q <= sel_data;
      end
    end
  end

  assign wb.acc_ready = ready_q;
  assign wb.write_reg = write_reg_q;
  assign wb.rd        = rd_q;
  assign wb.data_in   = data_q;
  assign wb.stall_rs1 = pending_q[wb.rs1];
  assign wb.stall_rs2 = pending_q[wb.rs2];

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-side front end of the core's 32×32 register file. It merges two writeback sources into the file's single write port (`write_reg`/`rd`/`data_in`, sampled by the file on the falling edge): the in-order core pipeline and the GEMM accelerator / long-latency result path. It buffers accelerator results in a small FIFO and tracks registers with outstanding accelerator results in a pending scoreboard, so decode can stall on true dependencies.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: accelerator result entries buffered; power of two, ≥2.
- `DATA_W`, 32: register data width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `core_wb_en`  in  1  core pipeline writeback valid this cycle; never back-pressured.
- `core_rd`  in  5  core destination register.
- `core_data`  in  DATA_W  core writeback data.
- `acc_valid`  in  1  accelerator result offered.
- `acc_ready`  out  1  arbiter accepts the result this cycle.
- `acc_rd`  in  5  accelerator destination register.
- `acc_data`  in  DATA_W  accelerator result data.
- `acc_issue_en`  in  1  accelerator op issued; mark `acc_issue_rd` pending.
- `acc_issue_rd`  in  5  destination of the issued op.
- `rs1`, `rs2`  in  5 each  decode source registers to check.
- `stall_rs1`, `stall_rs2`  out  1 each  source is pending.
- `write_reg`  out  1  register-file write enable (registered).
- `rd`  out  5  register-file write address (registered).
- `data_in`  out  DATA_W  register-file write data (registered).

## Operation
- Acceptance: an accelerator result is accepted when `acc_valid && acc_ready`. Accepted results are pushed into a FIFO of `FIFO_DEPTH` entries, each holding `{rd, data}`.
- `acc_ready = !full`. It is derived from registered state only, so it has no combinational path from `acc_valid`.
- Arbitration, evaluated each cycle:
  - If `core_wb_en` is high, the core write is loaded into the output register.
  - Otherwise, if the FIFO is not empty, the FIFO head is popped and loaded.
  - Otherwise `write_reg` goes to 0.
- The core always has priority. A FIFO entry waits as long as the core writes every cycle.
- Push and pop in the same cycle are both legal when the FIFO is not full. Occupancy is then unchanged and the pointers wrap modulo `FIFO_DEPTH`.
- x0 handling:
  - Any selected write with rd=0, from either source, yields `write_reg=0`, but it is still consumed.
  - `acc_issue_rd=0` is ignored.
  - x0 is never pending.
- Scoreboard: 32 pending bits.
  - Set on `acc_issue_en` for `acc_issue_rd`.
  - Cleared when an accelerator write to that rd is loaded into the output register.
  - If a set and a clear hit the same rd in the same cycle, the set wins.
  - A core write does not clear a pending bit.
- `stall_rsN = pending[rsN]`. This is combinational from the pending register; rs=0 gives 0.
- The issuer must not issue to an already-pending rd. The bench asserts this rule; the design behaviour in that case is undefined.

## Timing
- Reset values:
  - `write_reg=0`, `rd=0`, `data_in=0`.
  - `acc_ready=0` while `reset` is high, and 1 in the first cycle after `reset` falls.
  - Stall outputs 0, FIFO empty, all pending bits clear.
- Core latency is 1 cycle: `core_wb_en` at edge N gives `write_reg` high during cycle N+1. The register file writes on that cycle's falling edge.
- Accelerator latency is a minimum of 2 cycles: accepted at edge N, popped at edge N+1, `write_reg` high during N+1..N+2. It is longer when the core contends.
- Pending is cleared at the same edge the output register is loaded, so `stall` drops in the cycle in which the file write occurs.
- Full FIFO: `acc_ready=0` until a pop is committed. `acc_ready` returns to 1 the cycle after that pop.
- Reset mid-operation discards FIFO contents and pending bits. `write_reg` is 0 in the cycle following the reset edge.

## Configuration
- Macro `RF_WB_FIFO_BYPASS_EN`.
- Defined: if the FIFO is empty, `core_wb_en=0` and an accelerator result is accepted, the result loads the output register directly. Latency is 1 cycle and the FIFO is untouched.
- Undefined: every accelerator result passes through the FIFO, with a minimum latency of 2 cycles.

## Test plan
- Reset → all outputs 0. One cycle after reset deasserts, `acc_ready=1` and the stall outputs are 0.
- Core write: `core_wb_en=1`, `core_rd=5`, `core_data=0xDEADBEEF` → next cycle `write_reg=1`, `rd=5`, `data_in=0xDEADBEEF`. A core write to rd=0 gives `write_reg=0`.
- Scoreboard sequence:
  - Issue to rd=10; `rs1=10` → `stall_rs1=1`.
  - Accelerator result rd=10, data=0x1234 → `write_reg` with `rd=10`, `data_in=0x1234`, and `stall_rs1=0` in the same cycle.
- Contention and fill:
  - Core writes every cycle for 6 cycles while the accelerator offers results 0x100–0x105 to rd 1–6.
  - Expected: `acc_ready` drops after 4 accepts. After the core stops, the entries drain in order at one per cycle. `acc_ready` rises again, and all 6 values arrive in order.
- Simultaneous push and pop:
  - FIFO holds 2 entries, no core write, and a new result is offered → occupancy stays 2. The pointer wraps correctly over 10 such cycles.
- Reset while the FIFO holds 3 entries and rd=7 is pending → no queued write ever appears, and `stall` for rs=7 reads 0.
- With `RF_WB_FIFO_BYPASS_EN` defined: idle arbiter, accelerator result to rd=3 → `write_reg` in the next cycle. Without the macro, it appears one cycle later.
